// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from operands latched at launch and committed to
// HI/LO on the edge that ends the last busy cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
  localparam int unsigned PW      = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_bz;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_finish;
  logic               w_uns;
  logic               w_is_div;
  logic [PW-1:0]      w_ext_a;
  logic [PW-1:0]      w_ext_b;
  logic [PW-1:0]      w_prod;
  logic [PW-1:0]      w_acc;
  logic [PW-1:0]      w_mres;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_mag_d;
  logic [WIDTH-1:0]   w_q_mag;
  logic [WIDTH-1:0]   w_r_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept = (r_state == S_IDLE) && start && !cancel;
  assign w_finish = (r_state == S_RUN) && !cancel && (r_cnt == '0);

  // Next-state logic: launch on accept, leave RUN on cancel or last cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_RUN;
      S_RUN:  if (cancel || (r_cnt == '0)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Remaining-cycle counter; loaded with LAT-1 so busy lasts exactly LAT cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (!op[2] && op[1]) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end else if (r_state == S_RUN) begin
      r_cnt <= (cancel || (r_cnt == '0)) ? '0 : r_cnt - CNT_W'(1);
    end
  end

  // Operand capture at launch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_bz <= 1'b0;
    end else if (w_accept) begin
      r_op <= op;
      r_a  <= a;
      r_b  <= b;
      r_bz <= (b == '0);
    end
  end

  // Result datapath: op[0] selects unsigned, op[2] accumulate, op[1] subtract/divide
  always_comb begin
    w_uns    = r_op[0];
    w_is_div = !r_op[2] && r_op[1];
    w_ext_a  = w_uns ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
    w_ext_b  = w_uns ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
    w_prod   = w_ext_a * w_ext_b;
    w_acc    = {r_hi, r_lo};
    if (r_op[2]) w_mres = r_op[1] ? (w_acc - w_prod) : (w_acc + w_prod);
    else         w_mres = w_prod;
    // Sign-magnitude division; most-negative / -1 falls out as most-negative, rem 0
    w_neg_a  = !w_uns && r_a[WIDTH-1];
    w_neg_b  = !w_uns && r_b[WIDTH-1];
    w_mag_a  = w_neg_a ? (WIDTH'(0) - r_a) : r_a;
    w_mag_b  = w_neg_b ? (WIDTH'(0) - r_b) : r_b;
    w_mag_d  = r_bz ? WIDTH'(1) : w_mag_b;
    w_q_mag  = w_mag_a / w_mag_d;
    w_r_mag  = w_mag_a % w_mag_d;
    w_quo    = (w_neg_a ^ w_neg_b) ? (WIDTH'(0) - w_q_mag) : w_q_mag;
    w_rem    = w_neg_a ? (WIDTH'(0) - w_r_mag) : w_r_mag;
  end

  // HI/LO: commit on completion, mthi/mtlo only while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      if (w_is_div) begin
        if (!r_bz) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end
      end else begin
        {r_hi, r_lo} <= w_mres;
      end
    end else if (r_state == S_IDLE) begin
      if (hi_we) r_hi <= wdata;
      if (lo_we) r_lo <= wdata;
    end
  end

  // Completion pulse and divide-by-zero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= w_finish;
      r_div_zero <= w_finish && w_is_div && r_bz;
    end
  end

  assign busy     = (r_state == S_RUN);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   errors = 0;
  int   checks = 0;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (done) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: hi=%h lo=%h dz=%b but no result expected", hi, lo, div_zero);
        end else begin
          m_e = exp_q.pop_front();
          if ({div_zero, hi, lo} !== m_e) begin
            errors++;
            $display("FAIL result: got dz=%b hi=%h lo=%h, expected dz=%b hi=%h lo=%h",
                     div_zero, hi, lo, m_e.dz, m_e.hi, m_e.lo);
          end
        end
      end else if (div_zero !== 1'b0) begin
        errors++;
        $display("FAIL dz_without_done: div_zero=%b expected 0", div_zero);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic write_hl(input logic [31:0] h, input logic [31:0] l);
    hi_we = 1'b1; wdata = h; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = l; tick();
    lo_we = 1'b0;
    chk("preload_hi", hi, h);
    chk("preload_lo", lo, l);
  endtask

  // Launch one op, verify busy length; tail=0 leaves us in the done cycle
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input int lat, input logic edz,
                        input logic [31:0] ehi, input logic [31:0] elo, input bit tail);
    int n;
    exp_q.push_back({edz, ehi, elo});
    op = o; a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(lat));
    chk({name, "_done"}, 32'(done), 32'd1);
    if (tail) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    run_op("mult",  3'b000, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
    run_op("div",   3'b010, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    write_hl(32'h11, 32'h22);
    run_op("divz",  3'b011, 32'd7, 32'd0, 10, 1'b1, 32'h11, 32'h22, 1'b1);
    write_hl(32'h0, 32'hFFFFFFFF);
    run_op("madd",  3'b100, 32'd1, 32'd1, 5, 1'b0, 32'h1, 32'h0, 1'b1);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 32'hFFFFFFFE, 32'h1, 1'b1);
    run_op("msub",  3'b110, 32'd2, 32'd3, 5, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 1'b1);
    run_op("divmin", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 32'h0, 32'h80000000, 1'b1);
    run_op("divu",  3'b011, 32'd100, 32'd7, 10, 1'b0, 32'h2, 32'hE, 1'b1);
    run_op("divneg", 3'b010, 32'd7, 32'hFFFFFFFE, 10, 1'b0, 32'h1, 32'hFFFFFFFD, 1'b1);
    // Back-to-back: second launch in the done cycle of the first
    run_op("b2b_mult", 3'b000, 32'd4, 32'd5, 5, 1'b0, 32'h0, 32'h14, 1'b0);
    run_op("b2b_maddu", 3'b101, 32'd3, 32'd3, 5, 1'b0, 32'h0, 32'h1D, 1'b1);
    // Write in the launch cycle takes effect and the op still runs
    lo_we = 1'b1; wdata = 32'h100;
    run_op("wr_start", 3'b100, 32'd2, 32'd2, 5, 1'b0, 32'h0, 32'h104, 1'b1);

    // Cancel in the third busy cycle; writes during RUN are ignored
    write_hl(32'h5, 32'h6);
    op = 3'b000; a = 32'd2; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD;
    tick();
    hi_we = 1'b0;
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", 32'(busy), 32'd0);
    repeat (8) tick();
    chk("cancel_hi", hi, 32'h5);
    chk("cancel_lo", lo, 32'h6);
    start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    chk("start_cancel_busy", 32'(busy), 32'd0);
    tick();
    chk("start_cancel_busy2", 32'(busy), 32'd0);

    // Reset in the fourth busy cycle of a divu
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    repeat (12) tick();
    chk("rst_mid_hi_late", hi, 32'h0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
